hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core: the producer of the stall, flush and forward-select signals that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage operand muxes consume. It handles three cases:
- Load-use hazards.
- Taken-branch/jump redirects, from PC_SEL.
- Multi-cycle data-memory waits, with a timeout that halts the core.

It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_unit_if.sv | 36 +++
 rtl/hazard_ctrl_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline register indices, write enables, redirect
// and data-memory handshake in; stall/flush/forward controls and counters out.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RS1_D, RS2_D;
    logic [4:0]       RS1_E, RS2_E, RD_E;
    logic             REG_WRITE_EN_E;
    logic [1:0]       WB_SEL_E;
    logic [4:0]       RD_M, RD_W;
    logic             REG_WRITE_EN_M, REG_WRITE_EN_W;
    logic             PC_SEL;
    logic             MEM_REQ_M;
    logic             MEM_ACK;
    logic             STALL_F, STALL_D, STALL_E, STALL_M;
    logic             FLUSH_D, FLUSH_E;
    logic [1:0]       FWD_DATA1_E, FWD_DATA2_E;
    logic             MEM_ERR;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

    // Core side: drives pipeline state, consumes controls.
    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, REG_WRITE_EN_E, WB_SEL_E,
               RD_M, RD_W, REG_WRITE_EN_M, REG_WRITE_EN_W, PC_SEL, MEM_REQ_M, MEM_ACK,
        input  STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E,
               FWD_DATA1_E, FWD_DATA2_E, MEM_ERR, STALL_CNT, FLUSH_CNT
    );

    // Hazard unit side.
    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, REG_WRITE_EN_E, WB_SEL_E,
               RD_M, RD_W, REG_WRITE_EN_M, REG_WRITE_EN_W, PC_SEL, MEM_REQ_M, MEM_ACK,
        output STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E,
               FWD_DATA1_E, FWD_DATA2_E, MEM_ERR, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the five-stage RV32 core.
// Produces stall/flush/forward controls, tracks data-memory waits with a
// timeout that halts the core, and keeps saturating stall/flush counters.
// Optional feature macro: HAZARD_FWD_EN (operand forwarding; only load-use
// stalls). Undefined: no forwarding, any RAW dependency in ID stalls.
module hazard_ctrl_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               RST,
    hazard_ctrl_unit_if.slave  hz
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic             mem_err, mem_err_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_all, stall_fd, flush_d, flush_e;
    logic             hazard_d;
    logic [1:0]       fwd1, fwd2;
    logic             stall_f_out, flush_d_out;

    // A producer only matters if it writes a nonzero rd; x0 never matches.
    function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

`ifdef HAZARD_FWD_EN
    // ID dependency on a load in EX is the only case forwarding cannot cover.
    assign hazard_d = (hz.WB_SEL_E == 2'b01) &&
                      (reg_match(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS1_D) ||
                       reg_match(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS2_D));

    // Operand source select: the younger MEM result wins over WB.
    always_comb begin
        fwd1 = 2'b00;
        fwd2 = 2'b00;
        if (reg_match(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS1_E))      fwd1 = 2'b10;
        else if (reg_match(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS1_E)) fwd1 = 2'b01;
        if (reg_match(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS2_E))      fwd2 = 2'b10;
        else if (reg_match(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS2_E)) fwd2 = 2'b01;
    end
`else
    // Without forwarding, ID waits until no in-flight producer targets its sources.
    assign hazard_d = reg_match(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS1_D) ||
                      reg_match(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS2_D) ||
                      reg_match(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS1_D) ||
                      reg_match(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS2_D) ||
                      reg_match(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS1_D) ||
                      reg_match(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS2_D);
    assign fwd1 = 2'b00;
    assign fwd2 = 2'b00;
`endif

    // Next state and raw stall/flush decisions: memory wait > redirect > data hazard.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        stall_all    = 1'b0;
        stall_fd     = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        case (state)
            RUN: begin
                if (hz.MEM_REQ_M && !hz.MEM_ACK) begin
                    stall_all    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (hz.PC_SEL) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (hazard_d) begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so redirect/load-use are re-evaluated after exit.
                if (hz.MEM_ACK) begin
                    state_nxt = RUN;
                end else begin
                    stall_all = 1'b1;
                    if (wait_cnt >= TIMEOUT_W) begin
                        state_nxt   = HALT;
                        mem_err_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            HALT: begin
                stall_all = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Reset masks every control output in the same cycle.
    assign stall_f_out    = !RST && (stall_all || stall_fd);
    assign flush_d_out    = !RST && flush_d;
    assign hz.STALL_F     = stall_f_out;
    assign hz.STALL_D     = stall_f_out;
    assign hz.STALL_E     = !RST && stall_all;
    assign hz.STALL_M     = !RST && stall_all;
    assign hz.FLUSH_D     = flush_d_out;
    assign hz.FLUSH_E     = !RST && flush_e;
    assign hz.FWD_DATA1_E = RST ? 2'b00 : fwd1;
    assign hz.FWD_DATA2_E = RST ? 2'b00 : fwd2;
    assign hz.MEM_ERR     = mem_err;
    assign hz.STALL_CNT   = stall_cnt;
    assign hz.FLUSH_CNT   = flush_cnt;

    // State register, wait counter, sticky error and saturating event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err   <= mem_err_nxt;
            stall_cnt <= sat_inc(stall_cnt, stall_f_out);
            flush_cnt <= sat_inc(flush_cnt, flush_d_out);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: directed steps then randomized cycles, all
// checked against a behavioural model built from the hazard rules.
module tb_hazard_ctrl_unit;

    localparam int TMO   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    bit m_wait, m_halt, m_err;
    int m_wcnt, m_scnt, m_fcnt;
    // Expected combinational outputs.
    bit   e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
    logic [1:0] e_f1, e_f2;

    hazard_ctrl_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mt(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return (we === 1'b1) && (rd != 5'd0) && (rd == rs);
    endfunction

    // Expected stall/flush/forward for the current inputs and model state.
    task automatic model_comb();
        bit haz;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = 6'b0;
        e_f1 = 2'b00;
        e_f2 = 2'b00;
        if (RST) return;
`ifdef HAZARD_FWD_EN
        e_f1 = mt(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS1_E) ? 2'b10 :
               mt(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS1_E) ? 2'b01 : 2'b00;
        e_f2 = mt(hz.REG_WRITE_EN_M, hz.RD_M, hz.RS2_E) ? 2'b10 :
               mt(hz.REG_WRITE_EN_W, hz.RD_W, hz.RS2_E) ? 2'b01 : 2'b00;
        haz = (hz.WB_SEL_E == 2'b01) &&
              (mt(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS1_D) || mt(hz.REG_WRITE_EN_E, hz.RD_E, hz.RS2_D));
`else
        haz = 1'b0;
        foreach (hz.RS1_D[i]) begin end
        for (int s = 0; s < 2; s++) begin
            logic [4:0] rs;
            rs = (s == 0) ? hz.RS1_D : hz.RS2_D;
            if (mt(hz.REG_WRITE_EN_E, hz.RD_E, rs) || mt(hz.REG_WRITE_EN_M, hz.RD_M, rs) ||
                mt(hz.REG_WRITE_EN_W, hz.RD_W, rs))
                haz = 1'b1;
        end
`endif
        if (m_halt || (m_wait && !hz.MEM_ACK) || (!m_wait && hz.MEM_REQ_M && !hz.MEM_ACK))
            {e_sf, e_sd, e_se, e_sm} = 4'hF;
        else if (m_wait)
            ;
        else if (hz.PC_SEL)
            {e_fd, e_fe} = 2'b11;
        else if (haz)
            {e_sf, e_sd, e_fe} = 3'b111;
    endtask

    // Model view of what the clock edge does.
    task automatic model_edge();
        if (RST) begin
            m_wait = 0; m_halt = 0; m_err = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
            return;
        end
        if (e_sf && m_scnt < CMAX) m_scnt++;
        if (e_fd && m_fcnt < CMAX) m_fcnt++;
        if (m_halt) begin
        end else if (m_wait) begin
            if (hz.MEM_ACK) m_wait = 0;
            else if (m_wcnt == TMO) begin m_wait = 0; m_halt = 1; m_err = 1; end
            else m_wcnt++;
        end else if (hz.MEM_REQ_M && !hz.MEM_ACK) begin
            m_wait = 1;
            m_wcnt = 1;
        end
    endtask

    // Check every output against the model, then clock once and check registers.
    task automatic step(input string tag);
        model_comb();
        chk({tag, ".STALL_F"}, 32'(hz.STALL_F), 32'(e_sf));
        chk({tag, ".STALL_D"}, 32'(hz.STALL_D), 32'(e_sd));
        chk({tag, ".STALL_E"}, 32'(hz.STALL_E), 32'(e_se));
        chk({tag, ".STALL_M"}, 32'(hz.STALL_M), 32'(e_sm));
        chk({tag, ".FLUSH_D"}, 32'(hz.FLUSH_D), 32'(e_fd));
        chk({tag, ".FLUSH_E"}, 32'(hz.FLUSH_E), 32'(e_fe));
        chk({tag, ".FWD1"}, 32'(hz.FWD_DATA1_E), 32'(e_f1));
        chk({tag, ".FWD2"}, 32'(hz.FWD_DATA2_E), 32'(e_f2));
        model_edge();
        @(posedge CLK);
        #1;
        chk({tag, ".MEM_ERR"}, 32'(hz.MEM_ERR), 32'(m_err));
        chk({tag, ".STALL_CNT"}, 32'(hz.STALL_CNT), 32'(m_scnt));
        chk({tag, ".FLUSH_CNT"}, 32'(hz.FLUSH_CNT), 32'(m_fcnt));
    endtask

    task automatic clear_inputs();
        hz.RS1_D = 0; hz.RS2_D = 0; hz.RS1_E = 0; hz.RS2_E = 0; hz.RD_E = 0;
        hz.REG_WRITE_EN_E = 0; hz.WB_SEL_E = 0; hz.RD_M = 0; hz.RD_W = 0;
        hz.REG_WRITE_EN_M = 0; hz.REG_WRITE_EN_W = 0; hz.PC_SEL = 0;
        hz.MEM_REQ_M = 0; hz.MEM_ACK = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1;
        #2;
        step("reset");
        RST = 0;
    endtask

    task automatic set_load_use();
        hz.WB_SEL_E = 2'b01; hz.REG_WRITE_EN_E = 1; hz.RD_E = 7; hz.RS2_D = 7;
    endtask

    initial begin
        clear_inputs();
        m_wait = 0; m_halt = 0; m_err = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
        RST = 1;
        @(posedge CLK);
        #1;
        // Outputs forced low during reset even with live hazards.
        set_load_use();
        hz.PC_SEL = 1;
        hz.MEM_REQ_M = 1;
        #2;
        chk("rst_stall_m", 32'(hz.STALL_M), 32'd0);
        chk("rst_flush_d", 32'(hz.FLUSH_D), 32'd0);
        step("rst_forced");
        chk("rst_cnt", 32'(hz.STALL_CNT), 32'd0);
        do_reset();
        step("idle");

        // Forwarding: MEM beats WB, then WB alone.
        hz.RD_M = 5; hz.REG_WRITE_EN_M = 1; hz.RD_W = 5; hz.REG_WRITE_EN_W = 1;
        hz.RS1_E = 5; hz.RS2_E = 0;
        #2;
`ifdef HAZARD_FWD_EN
        chk("fwd_mem", 32'(hz.FWD_DATA1_E), 32'd2);
`else
        chk("fwd_tied", 32'(hz.FWD_DATA1_E), 32'd0);
`endif
        chk("fwd_rs2_x0", 32'(hz.FWD_DATA2_E), 32'd0);
        step("fwd_mw");
        hz.REG_WRITE_EN_M = 0;
        #2;
`ifdef HAZARD_FWD_EN
        chk("fwd_wb", 32'(hz.FWD_DATA1_E), 32'd1);
`else
        chk("fwd_wb_tied", 32'(hz.FWD_DATA1_E), 32'd0);
`endif
        step("fwd_w");

        // Load-use: one stall cycle, then the load is in MEM.
        do_reset();
        set_load_use();
        #2;
        chk("lu_stall_f", 32'(hz.STALL_F), 32'd1);
        chk("lu_flush_e", 32'(hz.FLUSH_E), 32'd1);
        chk("lu_stall_m", 32'(hz.STALL_M), 32'd0);
        step("load_use");
        chk("lu_cnt", 32'(hz.STALL_CNT), 32'd1);
        clear_inputs();
        hz.RD_M = 7; hz.REG_WRITE_EN_M = 1; hz.RS2_E = 7;
        #2;
        chk("lu_after_stall", 32'(hz.STALL_F), 32'd0);
`ifdef HAZARD_FWD_EN
        chk("lu_after_fwd", 32'(hz.FWD_DATA2_E), 32'd2);
`endif
        step("lu_after");
        clear_inputs();
        set_load_use();
        hz.RD_E = 0; hz.RS2_D = 0;
        #2;
        chk("lu_x0", 32'(hz.STALL_F), 32'd0);
        step("lu_x0");

        // Redirect overrides load-use.
        do_reset();
        set_load_use();
        hz.PC_SEL = 1;
        #2;
        chk("redir_fd", 32'(hz.FLUSH_D), 32'd1);
        chk("redir_sf", 32'(hz.STALL_F), 32'd0);
        step("redirect");
        chk("redir_cnt", 32'(hz.FLUSH_CNT), 32'd1);

        // Memory wait: ACK on 4th cycle -> 3 stall cycles.
        do_reset();
        hz.MEM_REQ_M = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_stall_m", 32'(hz.STALL_M), 32'd1);
            step("mem_wait");
        end
        hz.MEM_ACK = 1;
        hz.PC_SEL = 1;
        #2;
        chk("mw_ack_stall", 32'(hz.STALL_F), 32'd0);
        chk("mw_ack_noflush", 32'(hz.FLUSH_D), 32'd0);
        step("mem_ack");
        chk("mw_cnt", 32'(hz.STALL_CNT), 32'd3);
        clear_inputs();
        hz.PC_SEL = 1;
        #2;
        chk("mw_run_again", 32'(hz.FLUSH_D), 32'd1);
        step("mw_run");

        // Timeout: 1 RUN cycle + 4 wait cycles, then HALT.
        do_reset();
        hz.MEM_REQ_M = 1;
        for (int i = 0; i < 5; i++) begin
            #2;
            step("timeout");
            if (i == 3) chk("to_err_early", 32'(hz.MEM_ERR), 32'd0);
        end
        chk("to_err", 32'(hz.MEM_ERR), 32'd1);
        hz.MEM_REQ_M = 0; hz.MEM_ACK = 1; hz.PC_SEL = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("halt_stall_m", 32'(hz.STALL_M), 32'd1);
            chk("halt_flush", 32'(hz.FLUSH_D), 32'd0);
            step("halt");
        end
        do_reset();
        chk("to_rst_err", 32'(hz.MEM_ERR), 32'd0);
        chk("to_rst_cnt", 32'(hz.STALL_CNT), 32'd0);

        // RAW on MEM producer: stalls only without forwarding, and repeats.
        hz.RD_M = 3; hz.REG_WRITE_EN_M = 1; hz.RS1_D = 3;
        for (int i = 0; i < 2; i++) begin
            #2;
`ifdef HAZARD_FWD_EN
            chk("raw_m_fwd", 32'(hz.STALL_F), 32'd0);
`else
            chk("raw_m_stall", 32'(hz.STALL_F), 32'd1);
            chk("raw_m_flush_e", 32'(hz.FLUSH_E), 32'd1);
`endif
            chk("raw_m_fwd1", 32'(hz.FWD_DATA1_E), 32'd0);
            step("raw_m");
        end

        // Counter saturation.
        do_reset();
        set_load_use();
        for (int i = 0; i < CMAX + 3; i++) begin
            #2;
            step("sat");
        end
        chk("sat_cnt", 32'(hz.STALL_CNT), 32'(CMAX));

        // Randomized cycles.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 39) == 0);
            hz.RS1_D = 5'($urandom_range(0, 3)); hz.RS2_D = 5'($urandom_range(0, 3));
            hz.RS1_E = 5'($urandom_range(0, 3)); hz.RS2_E = 5'($urandom_range(0, 3));
            hz.RD_E  = 5'($urandom_range(0, 3)); hz.RD_M  = 5'($urandom_range(0, 3));
            hz.RD_W  = 5'($urandom_range(0, 3));
            hz.REG_WRITE_EN_E = 1'($urandom); hz.REG_WRITE_EN_M = 1'($urandom);
            hz.REG_WRITE_EN_W = 1'($urandom); hz.WB_SEL_E = 2'($urandom);
            hz.PC_SEL    = ($urandom_range(0, 3) == 0);
            hz.MEM_REQ_M = ($urandom_range(0, 3) == 0);
            hz.MEM_ACK   = ($urandom_range(0, 2) == 0);
            #2;
            step("rand");
        end
        RST = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
